// File: rtl/rns_9_8_7_pkg.sv
// Shared constants and state encoding for the {7,8,9} RNS mixed-radix reverse converter.
package rns_9_8_7_pkg;

  localparam int unsigned MOD1    = 7;
  localparam int unsigned MOD2    = 8;
  localparam int unsigned MOD3    = 9;
  localparam int unsigned M_RANGE = MOD1 * MOD2 * MOD3;

  localparam int unsigned W1 = 3;
  localparam int unsigned W2 = 3;
  localparam int unsigned W3 = 4;
  localparam int unsigned WX = 9;

  // Multiplicative inverses used by the MRC digit recurrences
  localparam logic [2:0] INV7_MOD8 = 3'd7;
  localparam logic [3:0] INV7_MOD9 = 4'd4;
  localparam logic [3:0] INV8_MOD9 = 4'd8;

  typedef enum logic [2:0] {IDLE, CALC_V2, CALC_V3, ACC, OUT} state_t;

endpackage

// File: rtl/mod9_reduce.sv
// Combinational residue reduction modulo 9 for small operands (0..71 in normal use).
module mod9_reduce
  import rns_9_8_7_pkg::*;
(
  input  logic [6:0]    x,
  output logic [W3-1:0] r
);

  assign r = W3'(x % 7'(MOD3));

endmodule

// File: rtl/rns_mrc_converter_9_8_7.sv
// Iterative mixed-radix converter: residues (mod 7, 8, 9) to a 9-bit binary value, fixed 3-clock latency.
module rns_mrc_converter_9_8_7
  import rns_9_8_7_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [W1-1:0] a1_in,
  input  logic [W2-1:0] a2_in,
  input  logic [W3-1:0] a3_in,
  input  logic          in_valid_in,
  output logic          in_ready_out,
  output logic [WX-1:0] res_out,
  output logic          err_out,
  output logic          out_valid_out,
  input  logic          out_ready_in
);

  state_t state_q, state_d;

  logic [W1-1:0] v1_q;
  logic [W2-1:0] a2_q;
  logic [W3-1:0] a3_q;
  logic          err_q;
  logic [W2-1:0] v2_q;
  logic [W3-1:0] v3_q;
  logic [WX-1:0] res_q;
  logic          err_out_q;
  logic          out_valid_q;

  logic          err_c;
  logic [W2-1:0] v2_c;
  logic [6:0]    d1, m1_in, m2_in;
  logic [W3-1:0] t1, d2, v3_c;
  logic [WX-1:0] x_c;

  assign err_c = (32'(a1_in) >= MOD1) || (32'(a3_in) >= MOD3);

  // 3-bit wraparound of the subtraction is exactly the mod-8 correction
  assign v2_c = W2'((a2_q - v1_q) * INV7_MOD8);

  assign d1    = 7'(a3_q) + 7'(MOD3) - 7'(v1_q);
  assign m1_in = 7'(d1 * 7'(INV7_MOD9));

  mod9_reduce u_red_a (.x(m1_in), .r(t1));

  // Pre-reduce the second difference so the product stays within the reducer's range
  assign d2    = (t1 >= W3'(v2_q)) ? t1 - W3'(v2_q) : t1 + W3'(MOD3) - W3'(v2_q);
  assign m2_in = 7'(7'(d2) * 7'(INV8_MOD9));

  mod9_reduce u_red_b (.x(m2_in), .r(v3_c));

  assign x_c = WX'(v1_q) + WX'(v2_q) * WX'(MOD1) + WX'(v3_q) * WX'(MOD1 * MOD2);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_in) state_d = CALC_V2;
      CALC_V2: state_d = CALC_V3;
      CALC_V3: state_d = ACC;
      ACC:     state_d = OUT;
      OUT:     if (out_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      err_q       <= 1'b0;
      v2_q        <= '0;
      v3_q        <= '0;
      res_q       <= '0;
      err_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_in) begin
          v1_q  <= a1_in;
          a2_q  <= a2_in;
          a3_q  <= a3_in;
          err_q <= CHECK_RANGE && err_c;
        end
        CALC_V2: v2_q <= v2_c;
        CALC_V3: v3_q <= v3_c;
        ACC: begin
          res_q       <= err_q ? '0 : x_c;
          err_out_q   <= err_q;
          out_valid_q <= 1'b1;
        end
        OUT: if (out_ready_in) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready_out  = (state_q == IDLE);
  assign res_out       = res_q;
  assign err_out       = err_out_q;
  assign out_valid_out = out_valid_q;

endmodule

// File: tb/tb_rns_mrc_converter_9_8_7.sv
// Scoreboard bench for the 9-8-7 MRC converter against a brute-force CRT reference.
module tb_rns_mrc_converter_9_8_7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a1, a2;
  logic [3:0] a3;
  logic       in_valid, in_ready, out_valid, out_ready, err;
  logic [8:0] res;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] sb[$];
  int cyc = 0;
  int acc_edge = 0;
  int n_acc = 0;
  int n_out = 0;
  bit prev_valid = 1'b0;
  bit prev_hs = 1'b0;
  logic [9:0] prev_out = '0;
  logic [8:0] last_res = '0;
  logic last_err = 1'b0;
  bit rand_ready = 1'b0;

  rns_mrc_converter_9_8_7 #(.CHECK_RANGE(1'b1)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .a1_in         (a1),
    .a2_in         (a2),
    .a3_in         (a3),
    .in_valid_in   (in_valid),
    .in_ready_out  (in_ready),
    .res_out       (res),
    .err_out       (err),
    .out_valid_out (out_valid),
    .out_ready_in  (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // CRT reference: search the whole dynamic range for the matching residues
  function automatic logic [9:0] ref_model(input int x1, input int x2, input int x3);
    if (x1 >= 7 || x3 >= 9) return {1'b1, 9'd0};
    for (int x = 0; x < 504; x++)
      if (x % 7 == x1 && x % 8 == x2 && x % 9 == x3) return {1'b0, 9'(x)};
    return '1;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (out_valid && !prev_valid) check("latency", cyc - acc_edge, 3);
      if (out_valid && prev_valid && !prev_hs) check("hold", {22'b0, err, res}, {22'b0, prev_out});
      if (out_valid && out_ready) begin
        n_out++;
        last_res = res;
        last_err = err;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_output: observed res %0d expected no output", res);
        end else begin
          logic [9:0] exp_v;
          exp_v = sb.pop_front();
          check("res", {23'b0, res}, {23'b0, exp_v[8:0]});
          check("err", {31'b0, err}, {31'b0, exp_v[9]});
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_model(a1, a2, a3));
        acc_edge = cyc + 1;
        n_acc++;
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_out   = {err, res};
    end
  end

  task automatic send(input logic [2:0] x1, input logic [2:0] x2, input logic [3:0] x3);
    int k;
    @(posedge clk);
    #1;
    a1 = x1; a2 = x2; a3 = x3; in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    check("accept", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((sb.size() != 0 || out_valid) && k < 400);
    check("drain", sb.size(), 0);
  endtask

  task automatic expect_last(input string tag, input int r, input bit e);
    check({tag, "_res"}, {23'b0, last_res}, r);
    check({tag, "_err"}, {31'b0, last_err}, {31'b0, e});
  endtask

  initial begin
    int n_before;
    int k;
    a1 = '0; a2 = '0; a3 = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_res", {23'b0, res}, 0);
    check("rst_err", {31'b0, err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // abort a conversion while it sits in CALC_V3
    send(3'd5, 3'd5, 4'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'b0, in_ready}, 1);
    check("abort_out_valid", {31'b0, out_valid}, 0);
    check("abort_res", {23'b0, res}, 0);
    check("abort_err", {31'b0, err}, 0);
    sb.delete();
    n_acc = n_out;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_valid", {31'b0, out_valid}, 0);
    end
    send(3'd0, 3'd0, 4'd0); drain(); expect_last("zero", 0, 1'b0);

    send(3'd3, 3'd2, 4'd1); drain(); expect_last("t321", 10, 1'b0);
    send(3'd6, 3'd7, 4'd8); drain(); expect_last("t678", 503, 1'b0);
    send(3'd3, 3'd7, 4'd3); drain(); expect_last("t373", 255, 1'b0);
    send(3'd0, 3'd0, 4'd9); drain(); expect_last("bad_a3", 0, 1'b1);
    send(3'd7, 3'd0, 4'd0); drain(); expect_last("bad_a1", 0, 1'b1);

    // backpressure with a competing triple presented while the result waits
    out_ready = 1'b0;
    send(3'd1, 3'd2, 4'd3);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    @(posedge clk);
    #1;
    a1 = 3'd2; a2 = 3'd2; a3 = 4'd2; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 0);
      check("bp_out_valid", {31'b0, out_valid}, 1);
      check("bp_res", {23'b0, res}, 498);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_before = n_out;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_one_hs", n_out - n_before, 1);
    check("bp_idle_ready", {31'b0, in_ready}, 1);
    check("bp_idle_valid", {31'b0, out_valid}, 0);
    check("bp_sb_empty", sb.size(), 0);
    expect_last("bp", 498, 1'b0);

    rand_ready = 1'b1;
    for (int unsigned i = 0; i < 7; i++)
      for (int unsigned j = 0; j < 8; j++)
        for (int unsigned m = 0; m < 9; m++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          send(3'(i), 3'(j), 4'(m));
        end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    check("count_in_out", n_out, n_acc);
    check("sb_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
